mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_SIZE, default 8, address width.
REQ-002 SHALL have parameter MEM_WORD_SIZE, default 32, data word width.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 15, max cycles waiting for memBusy to rise.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: req0, req1  input  1  access request, port 0 / port 1.
REQ-007 SHALL have ports: wr0, wr1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports: addr0, addr1  input  MEM_ADDR_SIZE  access address.
REQ-009 SHALL have ports: dataIn0, dataIn1  input  MEM_WORD_SIZE  write data.
REQ-010 SHALL have ports: ack0, ack1  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: err0, err1  output  1  timeout flag, valid with ack.
REQ-012 SHALL have ports: dataOut0, dataOut1  output  MEM_WORD_SIZE  read data, valid with ack.
REQ-013 SHALL have ports: memReq  output  1; memWr  output  1; memAddr  output  MEM_ADDR_SIZE; memDataIn  output  MEM_WORD_SIZE (to memory).
REQ-014 SHALL have ports: memBusy  input  1; memDataOut  input  MEM_WORD_SIZE (from memory).

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP; all outputs registered.
REQ-016 IDLE: if memBusy=0 and any req high, SHALL select a winner, latch its wr/addr/dataIn, store grant index, go ISSUE; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single request wins; both high -> port not granted last wins; lastGrant reset value 1, so port 0 wins first tie.
REQ-018 ISSUE: memReq=1 for exactly one cycle, memWr/memAddr/memDataIn from latched values; next state WAIT_BUSY, timeout counter cleared.
REQ-019 memWr/memAddr/memDataIn SHALL hold latched values from ISSUE through WAIT_DONE; requester inputs ignored after grant.
REQ-020 WAIT_BUSY: memBusy=1 -> WAIT_DONE; else counter increments; counter reaching BUSY_TIMEOUT -> RESP with err set.
REQ-021 WAIT_DONE: memBusy=0 -> capture memDataOut into granted port's dataOut (reads only; writes leave dataOut unchanged), go RESP; no timeout in this state.
REQ-022 RESP: granted port's ack=1 (and err if timed out) for exactly one cycle; other port's ack/err stay 0; lastGrant updated; next state IDLE.
REQ-023 err SHALL be 0 on normal completion; on timeout dataOut SHALL be unchanged.
REQ-024 Requester SHALL hold req, wr, addr, dataIn until ack and drop req no later than the edge leaving RESP; req still high in IDLE is a new request.
REQ-025 Latency without contention: grant edge to memReq = 1 cycle; ack follows memBusy falling edge by 1 cycle.
REQ-026 A request arriving while busy SHALL wait; at most one transaction outstanding.
REQ-027 Timeout counter SHALL be wide enough for BUSY_TIMEOUT and never wrap.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, memReq=0, memWr=0, memAddr=0, memDataIn=0, ack0/1=0, err0/1=0, dataOut0/1=0, lastGrant=1, counter=0.
REQ-029 Reset mid-transaction SHALL abort with no ack; first request after release is arbitrated as post-reset.

Verification
REQ-030 req0 write addr 3 data 0xDEADBEEF, memory busy 2 cycles -> one memReq pulse, memWr=1, memAddr=3, ack0 one cycle, err0=0.
REQ-031 req1 read addr 3 after REQ-030 -> dataOut1=0xDEADBEEF with ack1, ack0 stays 0.
REQ-032 req0 and req1 same cycle after reset, both held -> port 0 served first, then port 1; repeated ties alternate 0,1,0,1.
REQ-033 memBusy held 0 after memReq -> after BUSY_TIMEOUT (15) cycles ack=1, err=1, dataOut unchanged.
REQ-034 reset in WAIT_DONE -> all outputs 0 immediately, no ack; next request completes normally.
REQ-035 memBusy=1 when req0 rises in IDLE -> no memReq until memBusy=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two requesters share one
// memory with a busy handshake, one transaction at a time, busy timeout.
// Ports: clk, reset (async, active high).
//   Requester N: reqN, wrN, addrN, dataInN in; ackN, errN, dataOutN out.
//   Memory: memReq, memWr, memAddr, memDataIn out; memBusy, memDataOut in.
module mem_arbiter #(
  parameter int MEM_ADDR_SIZE = 8,
  parameter int MEM_WORD_SIZE = 32,
  parameter int BUSY_TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     wr0,
  input  logic                     wr1,
  input  logic [MEM_ADDR_SIZE-1:0] addr0,
  input  logic [MEM_ADDR_SIZE-1:0] addr1,
  input  logic [MEM_WORD_SIZE-1:0] dataIn0,
  input  logic [MEM_WORD_SIZE-1:0] dataIn1,
  output logic                     ack0,
  output logic                     ack1,
  output logic                     err0,
  output logic                     err1,
  output logic [MEM_WORD_SIZE-1:0] dataOut0,
  output logic [MEM_WORD_SIZE-1:0] dataOut1,
  output logic                     memReq,
  output logic                     memWr,
  output logic [MEM_ADDR_SIZE-1:0] memAddr,
  output logic [MEM_WORD_SIZE-1:0] memDataIn,
  input  logic                     memBusy,
  input  logic [MEM_WORD_SIZE-1:0] memDataOut
);

  localparam int CntW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } stateT;

  stateT state;
  stateT stateNext;

  logic            grant;
  logic            grantNext;
  logic            lastGrant;
  logic            lastGrantNext;
  logic            pick;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cntNext;

  logic                     memReqNext;
  logic                     memWrNext;
  logic [MEM_ADDR_SIZE-1:0] memAddrNext;
  logic [MEM_WORD_SIZE-1:0] memDataInNext;
  logic                     ack0Next;
  logic                     ack1Next;
  logic                     err0Next;
  logic                     err1Next;
  logic [MEM_WORD_SIZE-1:0] dataOut0Next;
  logic [MEM_WORD_SIZE-1:0] dataOut1Next;

  // Winner among current requests; on a tie the port
  // that did not win last time goes first.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      req0 && req1:  pick = ~lastGrant;
      req0 && !req1: pick = 1'b0;
      !req0 && req1: pick = 1'b1;
      default:       pick = 1'b0;
    endcase
  end

  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    lastGrantNext = lastGrant;
    cntNext       = cnt;
    memReqNext    = 1'b0;
    memWrNext     = memWr;
    memAddrNext   = memAddr;
    memDataInNext = memDataIn;
    ack0Next      = 1'b0;
    ack1Next      = 1'b0;
    err0Next      = 1'b0;
    err1Next      = 1'b0;
    dataOut0Next  = dataOut0;
    dataOut1Next  = dataOut1;

    unique case (state)
      IDLE: begin
        if (!memBusy && (req0 || req1)) begin
          grantNext     = pick;
          memReqNext    = 1'b1;
          memWrNext     = pick ? wr1 : wr0;
          memAddrNext   = pick ? addr1 : addr0;
          memDataInNext = pick ? dataIn1 : dataIn0;
          stateNext     = ISSUE;
        end
      end

      ISSUE: begin
        cntNext   = '0;
        stateNext = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (memBusy) begin
          stateNext = WAIT_DONE;
        end else if (cnt == CntLast) begin
          // This is the last allowed idle cycle: give up.
          stateNext = RESP;
          ack0Next  = ~grant;
          ack1Next  = grant;
          err0Next  = ~grant;
          err1Next  = grant;
        end else begin
          cntNext = cnt + CntW'(1);
        end
      end

      WAIT_DONE: begin
        if (!memBusy) begin
          stateNext = RESP;
          ack0Next  = ~grant;
          ack1Next  = grant;
          if (!memWr) begin
            if (grant) begin
              dataOut1Next = memDataOut;
            end else begin
              dataOut0Next = memDataOut;
            end
          end
        end
      end

      RESP: begin
        lastGrantNext = grant;
        stateNext     = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      lastGrant <= 1'b1;
      cnt       <= '0;
      memReq    <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memDataIn <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      dataOut0  <= '0;
      dataOut1  <= '0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      lastGrant <= lastGrantNext;
      cnt       <= cntNext;
      memReq    <= memReqNext;
      memWr     <= memWrNext;
      memAddr   <= memAddrNext;
      memDataIn <= memDataInNext;
      ack0      <= ack0Next;
      ack1      <= ack1Next;
      err0      <= err0Next;
      err1      <= err1Next;
      dataOut0  <= dataOut0Next;
      dataOut1  <= dataOut1Next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two requesters and a busy-handshake memory,
// checks mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    pReq;
  logic [1:0]    pWr;
  logic [AW-1:0] pAddr [2];
  logic [DW-1:0] pData [2];
  logic          memBusy;
  logic [DW-1:0] memDataOut;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] dataOut0, dataOut1;
  logic          memReq, memWr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDataIn;

  mem_arbiter #(
    .MEM_ADDR_SIZE(AW),
    .MEM_WORD_SIZE(DW),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(pReq[0]),
    .req1(pReq[1]),
    .wr0(pWr[0]),
    .wr1(pWr[1]),
    .addr0(pAddr[0]),
    .addr1(pAddr[1]),
    .dataIn0(pData[0]),
    .dataIn1(pData[1]),
    .ack0(ack0),
    .ack1(ack1),
    .err0(err0),
    .err1(err1),
    .dataOut0(dataOut0),
    .dataOut1(dataOut1),
    .memReq(memReq),
    .memWr(memWr),
    .memAddr(memAddr),
    .memDataIn(memDataIn),
    .memBusy(memBusy),
    .memDataOut(memDataOut)
  );

  int nChk = 0;
  int nPass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one transaction in flight, round-robin memory
  // of who went last, expected dataOut per port, expected memory.
  int            cyc;
  bit            inflight;
  int            txPort;
  bit            txWr;
  bit            txTO;
  logic [AW-1:0] txAddr;
  logic [DW-1:0] txData;
  int            issueCyc, lag, blen, ackCyc;
  int            lastGrantM;
  logic [DW-1:0] expOut [2];
  logic [DW-1:0] refMem [256];
  bit            prevMemReq;

  // Memory device model.
  logic [DW-1:0] devMem [256];
  bit            devWr;
  logic [AW-1:0] devAddr;
  logic [DW-1:0] devData;

  int reqPct, idleBusyPct, toPct, fixLag, fixBlen;
  bit forceTO, holdBusy;

  task automatic step();
    logic [1:0] ackExp;
    logic [1:0] errExp;
    bit done, keep;
    int w, ap;
    ackExp = '0;
    errExp = '0;
    done = 0;
    keep = 0;
    ap = 0;
    w = 0;
    if (inflight && cyc == ackCyc) begin
      done = 1;
      ap = txPort;
      ackExp[ap] = 1'b1;
      errExp[ap] = txTO;
      if (!txWr && !txTO) expOut[ap] = refMem[txAddr];
    end
    check("ack0", 64'(ack0), 64'(ackExp[0]));
    check("ack1", 64'(ack1), 64'(ackExp[1]));
    check("err0", 64'(err0), 64'(errExp[0]));
    check("err1", 64'(err1), 64'(errExp[1]));
    check("dataOut0", 64'(dataOut0), 64'(expOut[0]));
    check("dataOut1", 64'(dataOut1), 64'(expOut[1]));

    if (memReq) begin
      check("reqPulse", 64'(prevMemReq), 64'(0));
      check("busyAtGrant", 64'(memBusy), 64'(0));
      check("oneOutstanding", 64'(inflight), 64'(0));
      check("reqPending", 64'(pReq != 2'b00), 64'(1));
      if (pReq == 2'b11) w = (lastGrantM == 1) ? 0 : 1;
      else w = pReq[1] ? 1 : 0;
      check("memCmd", {23'b0, memWr, memAddr, memDataIn},
            {23'b0, pWr[w], pAddr[w], pData[w]});
      if (!inflight) begin
        inflight = 1;
        txPort = w;
        txWr = pWr[w];
        txAddr = pAddr[w];
        txData = pData[w];
        txTO = forceTO || (int'($urandom_range(0, 99)) < toPct);
        lag = fixLag > 0 ? fixLag : int'($urandom_range(1, 4));
        blen = fixBlen > 0 ? fixBlen : int'($urandom_range(1, 4));
        issueCyc = cyc;
        ackCyc = txTO ? cyc + 1 + TO : cyc + lag + blen + 1;
        devWr = memWr;
        devAddr = memAddr;
        devData = memDataIn;
      end
    end else if (inflight && !done) begin
      check("memHold", {23'b0, memWr, memAddr, memDataIn},
            {23'b0, txWr, txAddr, txData});
    end
    prevMemReq = memReq;

    if (done) begin
      inflight = 0;
      if (txWr && !txTO) refMem[txAddr] = txData;
      lastGrantM = ap;
      pReq[ap] = 1'b0;
    end

    if (inflight) begin
      if (cyc == issueCyc) begin
        memBusy = 1'b0;
      end else if (!txTO && cyc == issueCyc + lag) begin
        memBusy = 1'b1;
      end else if (!txTO && cyc == issueCyc + lag + blen) begin
        memBusy = 1'b0;
        memDataOut = devMem[devAddr];
        if (devWr) devMem[devAddr] = devData;
        keep = 1;
      end
    end else if (holdBusy) begin
      memBusy = 1'b1;
    end else if (memBusy) begin
      memBusy = 1'($urandom_range(0, 1));
    end else begin
      memBusy = int'($urandom_range(0, 99)) < idleBusyPct;
    end
    if (!keep) memDataOut = $urandom;

    for (int i = 0; i < 2; i++) begin
      if (!pReq[i] && !(done && ap == i)) begin
        if (int'($urandom_range(0, 99)) < reqPct) pReq[i] = 1'b1;
        pWr[i] = 1'($urandom);
        pAddr[i] = AW'($urandom_range(0, 7));
        pData[i] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    step();
  endtask

  task automatic post(int i, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    pReq[i] = 1'b1;
    pWr[i] = wr;
    pAddr[i] = a;
    pData[i] = d;
  endtask

  task automatic drain(int maxc);
    int k;
    k = 0;
    while ((pReq != 2'b00 || inflight) && k < maxc) begin
      tick();
      k++;
    end
    check("drain", 64'({inflight, pReq}), 64'(0));
  endtask

  task automatic checkReset();
    check("rstMemReq", 64'(memReq), 64'(0));
    check("rstMemWr", 64'(memWr), 64'(0));
    check("rstMemAddr", 64'(memAddr), 64'(0));
    check("rstMemDataIn", 64'(memDataIn), 64'(0));
    check("rstAck", 64'({ack1, ack0}), 64'(0));
    check("rstErr", 64'({err1, err0}), 64'(0));
    check("rstDataOut0", 64'(dataOut0), 64'(0));
    check("rstDataOut1", 64'(dataOut1), 64'(0));
  endtask

  task automatic applyReset();
    reset = 1'b1;
    inflight = 0;
    pReq = 2'b00;
    memBusy = 1'b0;
    expOut[0] = '0;
    expOut[1] = '0;
    lastGrantM = 1;
    prevMemReq = 0;
    #1;
    checkReset();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
  endtask

  initial begin
    pReq = 2'b00;
    pWr = 2'b00;
    pAddr[0] = '0;
    pAddr[1] = '0;
    pData[0] = '0;
    pData[1] = '0;
    memBusy = 1'b0;
    memDataOut = '0;
    cyc = 0;
    inflight = 0;
    lastGrantM = 1;
    expOut[0] = '0;
    expOut[1] = '0;
    prevMemReq = 0;
    reqPct = 0;
    idleBusyPct = 0;
    toPct = 0;
    fixLag = 0;
    fixBlen = 0;
    forceTO = 0;
    holdBusy = 0;
    for (int i = 0; i < 256; i++) begin
      refMem[i] = '0;
      devMem[i] = '0;
    end

    #2 reset = 1'b1;
    #1 checkReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back through the other port.
    fixLag = 1;
    fixBlen = 2;
    post(0, 1'b1, 8'd3, 32'hDEADBEEF);
    drain(60);
    post(1, 1'b0, 8'd3, 32'h0);
    drain(60);

    // Ties after reset: port 0 first, then port 1, twice.
    applyReset();
    post(0, 1'b1, 8'd1, 32'hA1A1A1A1);
    post(1, 1'b1, 8'd2, 32'hB2B2B2B2);
    drain(80);
    post(0, 1'b0, 8'd1, 32'h0);
    post(1, 1'b0, 8'd2, 32'h0);
    drain(80);

    // Memory never answers: timeout with err, dataOut kept.
    forceTO = 1;
    post(0, 1'b0, 8'd5, 32'h0);
    drain(60);
    forceTO = 0;

    // Memory busy while idle: request must wait.
    holdBusy = 1;
    tick();
    post(0, 1'b0, 8'd2, 32'h0);
    repeat (6) tick();
    holdBusy = 0;
    drain(60);

    // Reset while waiting for the memory to finish.
    fixLag = 1;
    fixBlen = 6;
    post(0, 1'b0, 8'd3, 32'h0);
    for (int k = 0; k < 20 && !(inflight && cyc == issueCyc + 2); k++) tick();
    check("reachWaitDone", 64'(inflight), 64'(1));
    applyReset();
    fixLag = 0;
    fixBlen = 0;
    post(1, 1'b1, 8'd4, 32'hC4C4C4C4);
    drain(60);
    post(0, 1'b0, 8'd4, 32'h0);
    drain(60);

    // Random traffic.
    reqPct = 30;
    idleBusyPct = 8;
    toPct = 10;
    repeat (3000) tick();
    reqPct = 0;
    idleBusyPct = 0;
    toPct = 0;
    drain(300);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
